// File: rtl/turn_scheduler_if.sv
// Handshake/bus bundle between the 1A2B turn scheduler and its front end, scorer and display.
// The slave modport is the scheduler's view; the master modport is the surrounding system's view.
interface turn_scheduler_if;
  logic        start;
  logic        guess_valid;
  logic [15:0] guess_in;
  logic        ack;
  logic [2:0]  score_a;
  logic [2:0]  score_b;
  logic [15:0] score_guess;
  logic        player;
  logic [3:0]  tries_left0;
  logic [3:0]  tries_left1;
  logic [5:0]  time_left;
  logic [2:0]  last_a;
  logic [2:0]  last_b;
  logic        result_valid;
  logic        reject;
  logic [1:0]  winner;
  logic        busy;

  modport slave (
    input  start, guess_valid, guess_in, ack, score_a, score_b,
    output score_guess, player, tries_left0, tries_left1, time_left,
           last_a, last_b, result_valid, reject, winner, busy
  );

  modport master (
    output start, guess_valid, guess_in, ack, score_a, score_b,
    input  score_guess, player, tries_left0, tries_left1, time_left,
           last_a, last_b, result_valid, reject, winner, busy
  );
endinterface

// File: rtl/turn_scheduler.sv
// Two-player 1A2B round controller: turn taking, attempt budgets, result latching, winner.
// Optional per-turn countdown with timeout forfeits is built when TURN_TIMER_EN is defined.
module turn_scheduler #(
  parameter int MAX_TRIES = 8,
  parameter int TURN_SECS = 30,
  parameter int TICK_DIV  = 100000000
) (
  input  logic            clk,
  input  logic            rst,
  turn_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TURN   = 3'd1,
    S_SCORE  = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  if (MAX_TRIES < 1 || MAX_TRIES > 15 || TURN_SECS < 1 || TURN_SECS > 63 || TICK_DIV < 2) begin : g_param_check
    $error("turn_scheduler: parameter out of range");
  end

  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [5:0] SECS_INIT  = 6'(TURN_SECS);

  // A guess is legal only with four decimal digits, all distinct.
  function automatic logic guess_ok(input logic [15:0] g);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (g[i*4 +: 4] > 4'd9) ok = 1'b0;
      for (int j = i + 1; j < 4; j++) begin
        if (g[i*4 +: 4] == g[j*4 +: 4]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] score_guess_q, score_guess_d;
  logic        player_q, player_d;
  logic [3:0]  tries0_q, tries0_d, tries1_q, tries1_d;
  logic [2:0]  last_a_q, last_a_d, last_b_q, last_b_d;
  logic        result_valid_q, result_valid_d;
  logic        reject_q, reject_d;
  logic [1:0]  winner_q, winner_d;
  logic        busy_q, busy_d;
  logic        forfeit_q, forfeit_d;
  logic        legal_s, timeout_s;
  logic [3:0]  dec0_s, dec1_s;

`ifdef TURN_TIMER_EN
  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    time_q, time_d;
  assign timeout_s     = (time_q == 6'd0);
  assign bus.time_left = time_q;
`else
  assign timeout_s     = 1'b0;
  assign bus.time_left = 6'd0;
`endif

  assign legal_s = guess_ok(bus.guess_in);
  // Attempts of the player being scored, saturating so an empty budget never wraps.
  assign dec0_s  = (!player_q && tries0_q != 4'd0) ? tries0_q - 4'd1 : tries0_q;
  assign dec1_s  = ( player_q && tries1_q != 4'd0) ? tries1_q - 4'd1 : tries1_q;

  // Next-state and next-output computation for the round FSM.
  always_comb begin
    state_d        = state_q;
    score_guess_d  = score_guess_q;
    player_d       = player_q;
    tries0_d       = tries0_q;
    tries1_d       = tries1_q;
    last_a_d       = last_a_q;
    last_b_d       = last_b_q;
    result_valid_d = 1'b0;
    reject_d       = 1'b0;
    winner_d       = winner_q;
    forfeit_d      = forfeit_q;
`ifdef TURN_TIMER_EN
    tick_d         = tick_q;
    time_d         = time_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_TURN;
          player_d  = 1'b0;
          tries0_d  = TRIES_INIT;
          tries1_d  = TRIES_INIT;
          winner_d  = 2'd0;
          forfeit_d = 1'b0;
`ifdef TURN_TIMER_EN
          tick_d    = '0;
          time_d    = SECS_INIT;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        reject_d = bus.guess_valid && !legal_s;
        if (bus.guess_valid && legal_s) begin
          score_guess_d = bus.guess_in;
          forfeit_d     = 1'b0;
          state_d       = S_SCORE;
        end else if (timeout_s) begin
          forfeit_d = 1'b1;
          state_d   = S_SCORE;
        end else begin
          state_d = S_TURN;
`ifdef TURN_TIMER_EN
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            time_d = (time_q == 6'd0) ? 6'd0 : time_q - 6'd1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
`endif
        end
      end
      S_SCORE: begin
        result_valid_d = 1'b1;
        tries0_d       = dec0_s;
        tries1_d       = dec1_s;
        if (forfeit_q) begin
          last_a_d = 3'd0;
          last_b_d = 3'd0;
        end else begin
          last_a_d = bus.score_a;
          last_b_d = bus.score_b;
        end
        if (!forfeit_q && bus.score_a == 3'd4) begin
          winner_d = player_q ? 2'd2 : 2'd1;
          state_d  = S_OVER;
        end else if (dec0_s == 4'd0 && dec1_s == 4'd0) begin
          winner_d = 2'd3;
          state_d  = S_OVER;
        end else begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (bus.ack) begin
          // Hand over only if the opponent still has attempts left.
          player_d  = (player_q ? tries0_q : tries1_q) != 4'd0 ? ~player_q : player_q;
          forfeit_d = 1'b0;
          state_d   = S_TURN;
`ifdef TURN_TIMER_EN
          tick_d    = '0;
          time_d    = SECS_INIT;
`endif
        end else begin
          state_d = S_RESULT;
        end
      end
      S_OVER: begin
        if (bus.ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      score_guess_q  <= 16'heeee;
      player_q       <= 1'b0;
      tries0_q       <= TRIES_INIT;
      tries1_q       <= TRIES_INIT;
      last_a_q       <= 3'd0;
      last_b_q       <= 3'd0;
      result_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      winner_q       <= 2'd0;
      busy_q         <= 1'b0;
      forfeit_q      <= 1'b0;
`ifdef TURN_TIMER_EN
      tick_q         <= '0;
      time_q         <= SECS_INIT;
`endif
    end else begin
      state_q        <= state_d;
      score_guess_q  <= score_guess_d;
      player_q       <= player_d;
      tries0_q       <= tries0_d;
      tries1_q       <= tries1_d;
      last_a_q       <= last_a_d;
      last_b_q       <= last_b_d;
      result_valid_q <= result_valid_d;
      reject_q       <= reject_d;
      winner_q       <= winner_d;
      busy_q         <= busy_d;
      forfeit_q      <= forfeit_d;
`ifdef TURN_TIMER_EN
      tick_q         <= tick_d;
      time_q         <= time_d;
`endif
    end
  end

  assign bus.score_guess  = score_guess_q;
  assign bus.player       = player_q;
  assign bus.tries_left0  = tries0_q;
  assign bus.tries_left1  = tries1_q;
  assign bus.last_a       = last_a_q;
  assign bus.last_b       = last_b_q;
  assign bus.result_valid = result_valid_q;
  assign bus.reject       = reject_q;
  assign bus.winner       = winner_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: main game, illegal guesses, win, draw and turn timer.
module tb_turn_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  turn_scheduler_if m ();
  turn_scheduler_if d ();
  turn_scheduler_if t ();

  turn_scheduler #(.MAX_TRIES(8), .TURN_SECS(30), .TICK_DIV(4)) dut   (.clk(clk), .rst(rst), .bus(m));
  turn_scheduler #(.MAX_TRIES(1), .TURN_SECS(30), .TICK_DIV(4)) dut_d (.clk(clk), .rst(rst), .bus(d));
  turn_scheduler #(.MAX_TRIES(8), .TURN_SECS(2),  .TICK_DIV(4)) dut_t (.clk(clk), .rst(rst), .bus(t));

  localparam logic [15:0] SECRET = 16'h1325;
`ifdef TURN_TIMER_EN
  localparam logic [5:0] EXP_TL = 6'd30;
`else
  localparam logic [5:0] EXP_TL = 6'd0;
`endif

  // Reference 1A2B scorer: A = right digit right place, B = right digit wrong place.
  function automatic logic [5:0] ab(input logic [15:0] g);
    logic [2:0] a, b;
    a = 3'd0;
    b = 3'd0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (g[i*4 +: 4] == SECRET[j*4 +: 4]) begin
          if (i == j) a = a + 3'd1;
          else        b = b + 3'd1;
        end
    return {a, b};
  endfunction

  assign m.score_a = ab(m.score_guess)[5:3];
  assign m.score_b = ab(m.score_guess)[2:0];
  assign d.score_a = ab(d.score_guess)[5:3];
  assign d.score_b = ab(d.score_guess)[2:0];
  assign t.score_a = 3'd2;
  assign t.score_b = 3'd1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m.start = 1'b1; step(); m.start = 1'b0; step();
    total_cnt++; if (m.busy !== 1'b1) $display("FAIL pre_reset_busy got %0b exp 1", m.busy); else pass_cnt++;
    rst = 1'b1; #2; rst = 1'b0; step();
    total_cnt++; if (m.busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", m.busy); else pass_cnt++;
    total_cnt++; if (m.score_guess !== 16'heeee) $display("FAIL reset_guess got %h exp eeee", m.score_guess); else pass_cnt++;
    total_cnt++; if (m.tries_left0 !== 4'd8 || m.tries_left1 !== 4'd8) $display("FAIL reset_tries got %0d/%0d exp 8/8", m.tries_left0, m.tries_left1); else pass_cnt++;
    total_cnt++; if (m.time_left !== EXP_TL) $display("FAIL reset_time got %0d exp %0d", m.time_left, EXP_TL); else pass_cnt++;
    total_cnt++; if ({m.player, m.winner, m.result_valid, m.reject, m.last_a, m.last_b} !== 11'd0) $display("FAIL reset_misc got %b exp 0", {m.player, m.winner, m.result_valid, m.reject, m.last_a, m.last_b}); else pass_cnt++;
  endtask

  task automatic test_score();
    m.start = 1'b1; step(); m.start = 1'b0;
    m.guess_in = 16'h1234; m.guess_valid = 1'b1; step(); m.guess_valid = 1'b0;
    total_cnt++; if (m.result_valid !== 1'b0 || m.score_guess !== 16'h1234) $display("FAIL score_lat1 got rv=%0b g=%h exp rv=0 g=1234", m.result_valid, m.score_guess); else pass_cnt++;
    step();
    total_cnt++; if (m.result_valid !== 1'b1) $display("FAIL score_rv got %0b exp 1", m.result_valid); else pass_cnt++;
    total_cnt++; if (m.last_a !== 3'd1 || m.last_b !== 3'd2) $display("FAIL score_ab got %0dA%0dB exp 1A2B", m.last_a, m.last_b); else pass_cnt++;
    total_cnt++; if (m.tries_left0 !== 4'd7 || m.tries_left1 !== 4'd8) $display("FAIL score_tries got %0d/%0d exp 7/8", m.tries_left0, m.tries_left1); else pass_cnt++;
    step();
    total_cnt++; if (m.result_valid !== 1'b0 || m.busy !== 1'b1 || m.player !== 1'b0) $display("FAIL score_wait got rv=%0b busy=%0b p=%0b exp 0/1/0", m.result_valid, m.busy, m.player); else pass_cnt++;
    m.ack = 1'b1; step(); m.ack = 1'b0;
    total_cnt++; if (m.player !== 1'b1) $display("FAIL score_switch got %0b exp 1", m.player); else pass_cnt++;
  endtask

  task automatic test_reject();
    m.guess_in = 16'h11a3; m.guess_valid = 1'b1; step(); m.guess_valid = 1'b0;
    total_cnt++; if (m.reject !== 1'b1) $display("FAIL reject_hex got %0b exp 1", m.reject); else pass_cnt++;
    step(); step();
    total_cnt++; if (m.reject !== 1'b0 || m.result_valid !== 1'b0) $display("FAIL reject_pulse got rej=%0b rv=%0b exp 0/0", m.reject, m.result_valid); else pass_cnt++;
    total_cnt++; if (m.tries_left1 !== 4'd8 || m.score_guess !== 16'h1234 || m.player !== 1'b1) $display("FAIL reject_state got t=%0d g=%h p=%0b exp 8/1234/1", m.tries_left1, m.score_guess, m.player); else pass_cnt++;
    m.guess_in = 16'h9879; m.guess_valid = 1'b1; step(); m.guess_valid = 1'b0;
    total_cnt++; if (m.reject !== 1'b1) $display("FAIL reject_repeat got %0b exp 1", m.reject); else pass_cnt++;
    m.ack = 1'b1; m.start = 1'b1; step(); m.ack = 1'b0; m.start = 1'b0; step();
    total_cnt++; if (m.player !== 1'b1 || m.busy !== 1'b1 || m.result_valid !== 1'b0) $display("FAIL ignore_ack got p=%0b busy=%0b rv=%0b exp 1/1/0", m.player, m.busy, m.result_valid); else pass_cnt++;
  endtask

  task automatic test_win();
    m.guess_in = 16'h1325; m.guess_valid = 1'b1; step(); m.guess_valid = 1'b0; step();
    total_cnt++; if (m.result_valid !== 1'b1 || m.last_a !== 3'd4 || m.last_b !== 3'd0) $display("FAIL win_ab got rv=%0b %0dA%0dB exp 1 4A0B", m.result_valid, m.last_a, m.last_b); else pass_cnt++;
    total_cnt++; if (m.winner !== 2'd2 || m.tries_left1 !== 4'd7) $display("FAIL win_winner got w=%0d t1=%0d exp 2/7", m.winner, m.tries_left1); else pass_cnt++;
    m.guess_in = 16'h4567; m.guess_valid = 1'b1; step(); m.guess_valid = 1'b0; step();
    total_cnt++; if (m.busy !== 1'b1 || m.winner !== 2'd2 || m.result_valid !== 1'b0) $display("FAIL win_over got busy=%0b w=%0d rv=%0b exp 1/2/0", m.busy, m.winner, m.result_valid); else pass_cnt++;
    m.ack = 1'b1; step(); m.ack = 1'b0;
    total_cnt++; if (m.busy !== 1'b0 || m.winner !== 2'd2 || m.last_a !== 3'd4) $display("FAIL win_idle got busy=%0b w=%0d a=%0d exp 0/2/4", m.busy, m.winner, m.last_a); else pass_cnt++;
    m.start = 1'b1; step(); m.start = 1'b0;
    total_cnt++; if (m.winner !== 2'd0 || m.player !== 1'b0 || m.tries_left1 !== 4'd8) $display("FAIL win_restart got w=%0d p=%0b t1=%0d exp 0/0/8", m.winner, m.player, m.tries_left1); else pass_cnt++;
  endtask

  task automatic test_draw();
    d.start = 1'b1; step(); d.start = 1'b0;
    d.guess_in = 16'h5678; d.guess_valid = 1'b1; step(); d.guess_valid = 1'b0; step();
    total_cnt++; if (d.result_valid !== 1'b1 || d.last_a !== 3'd0 || d.last_b !== 3'd1 || d.winner !== 2'd0 || d.tries_left0 !== 4'd0) $display("FAIL draw_p0 got rv=%0b %0dA%0dB w=%0d t0=%0d exp 1 0A1B 0 0", d.result_valid, d.last_a, d.last_b, d.winner, d.tries_left0); else pass_cnt++;
    d.ack = 1'b1; step(); d.ack = 1'b0;
    total_cnt++; if (d.player !== 1'b1) $display("FAIL draw_switch got %0b exp 1", d.player); else pass_cnt++;
    d.guess_in = 16'h9876; d.guess_valid = 1'b1; step(); d.guess_valid = 1'b0; step();
    total_cnt++; if (d.winner !== 2'd3 || d.tries_left1 !== 4'd0 || d.last_a !== 3'd0 || d.last_b !== 3'd0) $display("FAIL draw_result got w=%0d t1=%0d %0dA%0dB exp 3 0 0A0B", d.winner, d.tries_left1, d.last_a, d.last_b); else pass_cnt++;
    d.ack = 1'b1; step(); d.ack = 1'b0;
    total_cnt++; if (d.busy !== 1'b0 || d.winner !== 2'd3) $display("FAIL draw_idle got busy=%0b w=%0d exp 0/3", d.busy, d.winner); else pass_cnt++;
  endtask

  task automatic test_timer();
    int n;
    t.start = 1'b1; step(); t.start = 1'b0;
`ifdef TURN_TIMER_EN
    total_cnt++; if (t.time_left !== 6'd2) $display("FAIL timer_load got %0d exp 2", t.time_left); else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    total_cnt++; if (t.time_left !== 6'd1) $display("FAIL timer_tick got %0d exp 1", t.time_left); else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    total_cnt++; if (t.time_left !== 6'd0 || t.result_valid !== 1'b0) $display("FAIL timer_zero got tl=%0d rv=%0b exp 0/0", t.time_left, t.result_valid); else pass_cnt++;
    n = 0;
    while (n < 20 && t.result_valid !== 1'b1) begin step(); n++; end
    total_cnt++; if (n !== 2) $display("FAIL timer_forfeit_latency got %0d exp 2", n); else pass_cnt++;
    total_cnt++; if (t.last_a !== 3'd0 || t.last_b !== 3'd0 || t.tries_left0 !== 4'd7 || t.score_guess !== 16'heeee) $display("FAIL timer_forfeit got %0dA%0dB t0=%0d g=%h exp 0A0B 7 eeee", t.last_a, t.last_b, t.tries_left0, t.score_guess); else pass_cnt++;
    t.ack = 1'b1; step(); t.ack = 1'b0;
    total_cnt++; if (t.player !== 1'b1 || t.time_left !== 6'd2) $display("FAIL timer_reload got p=%0b tl=%0d exp 1/2", t.player, t.time_left); else pass_cnt++;
`else
    n = 0;
    for (int i = 0; i < 12; i++) begin step(); if (t.result_valid === 1'b1) n++; end
    total_cnt++; if (n !== 0 || t.busy !== 1'b1 || t.time_left !== 6'd0 || t.tries_left0 !== 4'd8) $display("FAIL notimer_wait got rv=%0d busy=%0b tl=%0d t0=%0d exp 0/1/0/8", n, t.busy, t.time_left, t.tries_left0); else pass_cnt++;
    t.guess_in = 16'h1234; t.guess_valid = 1'b1; step(); t.guess_valid = 1'b0; step();
    total_cnt++; if (t.result_valid !== 1'b1 || t.last_a !== 3'd2 || t.last_b !== 3'd1 || t.tries_left0 !== 4'd7) $display("FAIL notimer_guess got rv=%0b %0dA%0dB t0=%0d exp 1 2A1B 7", t.result_valid, t.last_a, t.last_b, t.tries_left0); else pass_cnt++;
`endif
  endtask

  initial begin
    m.start = 1'b0; m.guess_valid = 1'b0; m.guess_in = 16'h0000; m.ack = 1'b0;
    d.start = 1'b0; d.guess_valid = 1'b0; d.guess_in = 16'h0000; d.ack = 1'b0;
    t.start = 1'b0; t.guess_valid = 1'b0; t.guess_in = 16'h0000; t.ack = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_score();
    test_reject();
    test_win();
    test_draw();
    test_timer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
